// File: rtl/chain_relax_core_if.sv
// Frame control and node-position bus of a chain_relax_core.
// master drives start/mode/pin targets; slave returns status and node positions.
interface chain_relax_if #(
  parameter int unsigned NODES = 5,
  parameter int unsigned W     = 32
);
  logic               start;
  logic [1:0]         mode;
  logic [W-1:0]       mouse_x;
  logic [W-1:0]       mouse_y;
  logic [W-1:0]       anchor_x;
  logic [W-1:0]       anchor_y;
  logic               busy;
  logic               done;
  logic [NODES*W-1:0] nodes_x;
  logic [NODES*W-1:0] nodes_y;

  modport master (
    output start, mode, mouse_x, mouse_y, anchor_x, anchor_y,
    input  busy, done, nodes_x, nodes_y
  );

  modport slave (
    input  start, mode, mouse_x, mouse_y, anchor_x, anchor_y,
    output busy, done, nodes_x, nodes_y
  );
endinterface

// File: rtl/chain_relax_core.sv
// Rope-segment core: relaxes NODES 2-D points toward their neighbours' midpoint
// in ITERS red/black sweep pairs per start pulse, with optional pinned endpoints.
module chain_relax_core #(
  parameter int unsigned NODES      = 5,
  parameter int unsigned W          = 32,
  parameter int unsigned ITERS      = 4,
  parameter int unsigned DAMP_SHIFT = 0,
  parameter int unsigned SPACING    = 16,
  parameter int unsigned CORE_ID    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         has_prev,
  input  logic         has_next,
  input  logic [W-1:0] prev_last_x,
  input  logic [W-1:0] prev_last_y,
  input  logic [W-1:0] next_first_x,
  input  logic [W-1:0] next_first_y,
  chain_relax_if.slave bus
);
  localparam int unsigned CW       = $clog2(ITERS + 1);
  localparam int unsigned EW       = W + 2;
  localparam bit          TAIL_ODD = ((NODES - 1) % 2) == 1;

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NODES-1:0][W-1:0] x_q, x_d, y_q, y_d;
  logic [NODES-1:0][W-1:0] relax_x, relax_y;
  logic [1:0]              mode_q, mode_d;
  logic [W-1:0]            mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [W-1:0]            anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
  logic                    busy_q, busy_d, done_q, done_d;

  // One damped step toward floor((l+r)/2); result lies between p and the midpoint.
  function automatic logic [W-1:0] relax(input logic [W-1:0] p,
                                         input logic [W-1:0] l,
                                         input logic [W-1:0] r);
    logic signed [EW-1:0] pe, mid, step, sum;
    pe   = EW'($signed(p));
    mid  = (EW'($signed(l)) + EW'($signed(r))) >>> 1;
    step = (mid - pe) >>> DAMP_SHIFT;
    sum  = pe + step;
    return sum[W-1:0];
  endfunction

  for (genvar g = 0; g < NODES; g++) begin : g_node
    logic [W-1:0] lx, ly, rx, ry;
    if (g == 0) begin : g_lport
      assign lx = prev_last_x;
      assign ly = prev_last_y;
    end else begin : g_lreg
      assign lx = x_q[g-1];
      assign ly = y_q[g-1];
    end
    if (g == NODES - 1) begin : g_rport
      assign rx = next_first_x;
      assign ry = next_first_y;
    end else begin : g_rreg
      assign rx = x_q[g+1];
      assign ry = y_q[g+1];
    end
    assign relax_x[g] = relax(x_q[g], lx, rx);
    assign relax_y[g] = relax(y_q[g], ly, ry);
  end

  // Next-state, phase updates and endpoint pinning.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    mouse_x_d  = mouse_x_q;
    mouse_y_d  = mouse_y_q;
    anchor_x_d = anchor_x_q;
    anchor_y_d = anchor_y_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_EVEN;
          mode_d     = bus.mode;
          mouse_x_d  = bus.mouse_x;
          mouse_y_d  = bus.mouse_y;
          anchor_x_d = bus.anchor_x;
          anchor_y_d = bus.anchor_y;
        end
      end
      S_EVEN: begin
        for (int i = 0; i < int'(NODES); i += 2) begin
          x_d[i] = relax_x[i];
          y_d[i] = relax_y[i];
        end
        if (!has_prev) begin
          x_d[0] = mode_q[0] ? mouse_x_q : x_q[0];
          y_d[0] = mode_q[0] ? mouse_y_q : y_q[0];
        end
        if (!TAIL_ODD && !has_next) begin
          x_d[NODES-1] = mode_q[1] ? anchor_x_q : x_q[NODES-1];
          y_d[NODES-1] = mode_q[1] ? anchor_y_q : y_q[NODES-1];
        end
        state_d = S_ODD;
      end
      S_ODD: begin
        for (int i = 1; i < int'(NODES); i += 2) begin
          x_d[i] = relax_x[i];
          y_d[i] = relax_y[i];
        end
        if (TAIL_ODD && !has_next) begin
          x_d[NODES-1] = mode_q[1] ? anchor_x_q : x_q[NODES-1];
          y_d[NODES-1] = mode_q[1] ? anchor_y_q : y_q[NODES-1];
        end
        cnt_d   = CW'(cnt_q + 1'b1);
        state_d = (cnt_d == CW'(ITERS)) ? S_DONE : S_EVEN;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_EVEN) || (state_d == S_ODD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      for (int i = 0; i < int'(NODES); i++) begin
        x_q[i] <= W'(((CORE_ID - 1) * NODES + i) * SPACING);
        y_q[i] <= '0;
      end
      mode_q     <= '0;
      mouse_x_q  <= '0;
      mouse_y_q  <= '0;
      anchor_x_q <= '0;
      anchor_y_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      mode_q     <= mode_d;
      mouse_x_q  <= mouse_x_d;
      mouse_y_q  <= mouse_y_d;
      anchor_x_q <= anchor_x_d;
      anchor_y_q <= anchor_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.nodes_x = x_q;
  assign bus.nodes_y = y_q;
endmodule

// File: tb/tb_chain_relax_core.sv
// Bench for chain_relax_core: frame-level model checked every cycle, plus literal
// expectations for the hand-computed scenarios.
module tb_chain_relax_core;
  localparam int N = 5;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chain_relax_if #(.NODES(N), .W(W)) if0 ();
  chain_relax_if #(.NODES(N), .W(W)) if1 ();

  logic         hp0, hn0, hp1, hn1;
  logic [W-1:0] px0, py0, nx0, ny0, px1, py1, nx1, ny1;

  chain_relax_core #(.NODES(N), .W(W), .ITERS(1), .DAMP_SHIFT(0), .SPACING(16), .CORE_ID(1)) dut0 (
    .clk(clk), .reset(reset), .has_prev(hp0), .has_next(hn0),
    .prev_last_x(px0), .prev_last_y(py0), .next_first_x(nx0), .next_first_y(ny0),
    .bus(if0)
  );

  chain_relax_core #(.NODES(N), .W(W), .ITERS(3), .DAMP_SHIFT(1), .SPACING(10), .CORE_ID(2)) dut1 (
    .clk(clk), .reset(reset), .has_prev(hp1), .has_next(hn1),
    .prev_last_x(px1), .prev_last_y(py1), .next_first_x(nx1), .next_first_y(ny1),
    .bus(if1)
  );

  int checks   = 0;
  int failures = 0;
  int busy_cnt [2];
  int done_cnt [2];

  int iters [2] = '{1, 3};
  int damp  [2] = '{0, 1};

  longint mx [2][N];
  longint my [2][N];
  bit     mbusy [2];
  bit     mdone [2];
  int     mleft [2];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint dx(input int d, input int i);
    logic [N*W-1:0] v;
    v = (d == 0) ? if0.nodes_x : if1.nodes_x;
    return sx(v[i*W +: W]);
  endfunction

  function automatic longint dy(input int d, input int i);
    logic [N*W-1:0] v;
    v = (d == 0) ? if0.nodes_y : if1.nodes_y;
    return sx(v[i*W +: W]);
  endfunction

  function automatic logic dbusy(input int d);
    return (d == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic ddone(input int d);
    return (d == 0) ? if0.done : if1.done;
  endfunction

  function automatic void reset_model(input int d);
    for (int i = 0; i < N; i++) begin
      mx[d][i] = (d == 0) ? longint'(i * 16) : longint'(50 + i * 10);
      my[d][i] = 0;
    end
    mbusy[d] = 0;
    mdone[d] = 0;
    mleft[d] = 0;
  endfunction

  function automatic longint relax_pt(input longint p, input longint l, input longint r, input int dm);
    longint mid;
    mid = (l + r) >>> 1;
    return p + ((mid - p) >>> dm);
  endfunction

  // Whole frame computed at start from the latched pin targets and current neighbours.
  function automatic void model_frame(input int d);
    logic [1:0] md;
    longint ms_x, ms_y, an_x, an_y, pl_x, pl_y, nf_x, nf_y, lx, ly, rx, ry;
    bit hp, hn;
    longint ox [N];
    longint oy [N];
    md   = (d == 0) ? if0.mode : if1.mode;
    ms_x = sx((d == 0) ? if0.mouse_x : if1.mouse_x);
    ms_y = sx((d == 0) ? if0.mouse_y : if1.mouse_y);
    an_x = sx((d == 0) ? if0.anchor_x : if1.anchor_x);
    an_y = sx((d == 0) ? if0.anchor_y : if1.anchor_y);
    hp   = (d == 0) ? hp0 : hp1;
    hn   = (d == 0) ? hn0 : hn1;
    pl_x = sx((d == 0) ? px0 : px1);
    pl_y = sx((d == 0) ? py0 : py1);
    nf_x = sx((d == 0) ? nx0 : nx1);
    nf_y = sx((d == 0) ? ny0 : ny1);
    for (int it = 0; it < iters[d]; it++) begin
      for (int ph = 0; ph < 2; ph++) begin
        for (int i = 0; i < N; i++) begin
          ox[i] = mx[d][i];
          oy[i] = my[d][i];
        end
        for (int i = ph; i < N; i += 2) begin
          if (i == 0 && !hp) begin
            if (md[0]) begin mx[d][i] = ms_x; my[d][i] = ms_y; end
          end else if (i == N - 1 && !hn) begin
            if (md[1]) begin mx[d][i] = an_x; my[d][i] = an_y; end
          end else begin
            lx = (i == 0) ? pl_x : ox[i-1];
            ly = (i == 0) ? pl_y : oy[i-1];
            rx = (i == N - 1) ? nf_x : ox[i+1];
            ry = (i == N - 1) ? nf_y : oy[i+1];
            mx[d][i] = relax_pt(ox[i], lx, rx, damp[d]);
            my[d][i] = relax_pt(oy[i], ly, ry, damp[d]);
          end
        end
      end
    end
  endfunction

  // Frame timing model: busy for 2*ITERS cycles after the start edge, then one done cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) reset_model(d);
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mdone[d]) mdone[d] = 0;
        else if (mbusy[d]) begin
          mleft[d]--;
          if (mleft[d] == 0) begin mbusy[d] = 0; mdone[d] = 1; end
        end else if ((d == 0) ? if0.start : if1.start) begin
          model_frame(d);
          mbusy[d] = 1;
          mleft[d] = 2 * iters[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (dbusy(d)) busy_cnt[d]++;
        if (ddone(d)) done_cnt[d]++;
        chk($sformatf("d%0d_busy", d), longint'(dbusy(d)), longint'(mbusy[d]));
        chk($sformatf("d%0d_done", d), longint'(ddone(d)), longint'(mdone[d]));
        if (!mbusy[d]) begin
          for (int i = 0; i < N; i++) begin
            chk($sformatf("d%0d_x%0d", d, i), dx(d, i), mx[d][i]);
            chk($sformatf("d%0d_y%0d", d, i), dy(d, i), my[d][i]);
          end
        end
      end
    end
  end

  // Literal expectations compared against both the DUT and the model.
  task automatic expect_xy(input string nm, input int d, input longint ex [N], input longint ey [N]);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", nm, i), dx(d, i), ex[i]);
      chk($sformatf("%s_y%0d", nm, i), dy(d, i), ey[i]);
      chk($sformatf("%s_model_y%0d", nm, i), my[d][i], ey[i]);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) if0.start = v; else if1.start = v;
  endtask

  task automatic pulse(input int d);
    @(negedge clk); set_start(d, 1'b1);
    @(negedge clk); set_start(d, 1'b0);
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!ddone(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_done_timeout", d), longint'(n >= 100), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    longint ex [N];
    longint ey [N];
    longint e1 [N];
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin reset_model(d); busy_cnt[d] = 0; done_cnt[d] = 0; end
    if0.start = 0; if0.mode = 0; if0.mouse_x = 0; if0.mouse_y = 0; if0.anchor_x = 0; if0.anchor_y = 0;
    if1.start = 0; if1.mode = 0; if1.mouse_x = 0; if1.mouse_y = 0; if1.anchor_x = 0; if1.anchor_y = 0;
    hp0 = 0; hn0 = 0; px0 = 0; py0 = 0; nx0 = 0; ny0 = 0;
    hp1 = 1; hn1 = 1; px1 = 40; py1 = 6; nx1 = 100; ny1 = -4;
    ex = '{0, 16, 32, 48, 64};
    ey = '{0, 0, 0, 0, 0};
    e1 = '{50, 60, 70, 80, 90};

    repeat (2) @(negedge clk);
    expect_xy("rst", 0, ex, ey);
    expect_xy("rst1", 1, e1, ey);
    chk("rst_busy", longint'(if0.busy), 0);
    chk("rst_done", longint'(if0.done), 0);
    reset = 1'b0;

    // Collinear chain stays put
    @(negedge clk); busy_cnt[0] = 0; done_cnt[0] = 0;
    pulse(0); wait_done(0);
    chk("t2_busy_cycles", busy_cnt[0], 2);
    chk("t2_done_pulses", done_cnt[0], 1);
    expect_xy("t2", 0, ex, ey);

    // Head pinned to mouse; mid-frame target change must not matter
    do_reset();
    if0.mode = 2'd1; if0.mouse_x = 0; if0.mouse_y = 80;
    pulse(0);
    if0.mouse_y = 999; if0.mode = 2'd3;
    wait_done(0);
    ey = '{80, 40, 0, 0, 0};
    expect_xy("t3", 0, ex, ey);

    // Floor rounding of a negative midpoint
    do_reset();
    if0.mode = 2'd1; if0.mouse_x = 0; if0.mouse_y = -3;
    pulse(0); wait_done(0);
    ey = '{-3, -2, 0, 0, 0};
    expect_xy("t4", 0, ex, ey);

    // Tail pinned to anchor
    do_reset();
    if0.mode = 2'd2; if0.anchor_x = 64; if0.anchor_y = -8;
    pulse(0); wait_done(0);
    ey = '{0, 0, 0, -4, -8};
    expect_xy("t5", 0, ex, ey);

    // Start held high while busy is ignored
    do_reset();
    if0.mode = 2'd1; if0.mouse_x = 0; if0.mouse_y = 80;
    @(negedge clk); busy_cnt[0] = 0; done_cnt[0] = 0;
    if0.start = 1;
    repeat (3) @(negedge clk);
    if0.start = 0;
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("t6_done_pulses", done_cnt[0], 1);
    chk("t6_busy_cycles", busy_cnt[0], 2);

    // Reset during EVEN aborts the frame immediately
    done_cnt[0] = 0;
    @(negedge clk); if0.start = 1;
    @(negedge clk); if0.start = 0;
    chk("t6_in_even_busy", longint'(if0.busy), 1);
    reset = 1'b1;
    #1;
    ey = '{0, 0, 0, 0, 0};
    expect_xy("t6_abort", 0, ex, ey);
    chk("t6_abort_busy", longint'(if0.busy), 0);
    chk("t6_abort_done", longint'(if0.done), 0);
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_abort_no_done", done_cnt[0], 0);

    // Interior core with live neighbours, damped, several sweeps; pins ignored
    if1.mode = 2'd3; if1.mouse_x = 1; if1.mouse_y = 2; if1.anchor_x = 3; if1.anchor_y = 4;
    pulse(1); wait_done(1);
    // Rope head: pinned head, free (held) tail
    hp1 = 0; hn1 = 0; if1.mode = 2'd1; if1.mouse_x = 30; if1.mouse_y = 20;
    pulse(1); wait_done(1);
    // Rope tail: head follows prev core, tail pinned
    hp1 = 1; px1 = -7; py1 = 13; if1.mode = 2'd2; if1.anchor_x = 120; if1.anchor_y = -50;
    pulse(1); wait_done(1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
